// File: rtl/jpeg_block_stream_adapter.sv
// Double-buffered 8x8 block packer and zigzag serialiser around an
// external fixed-latency JPEG core, with AXI-Stream on both sides.
module jpeg_block_stream_adapter #(
  parameter int DATA_WIDTH   = 32,
  parameter int INPUT_WIDTH  = 8,
  parameter int DATA_DEPTH   = 8,
  parameter int PIXEL_COUNT  = DATA_DEPTH*DATA_DEPTH,
  parameter int NUM_CH       = 3,
  parameter int CORE_LATENCY = 4,
  parameter int TLAST_MODE   = 0
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [3*INPUT_WIDTH-1:0]              s_axis_tdata,
  input  logic                                  s_axis_tvalid,
  output logic                                  s_axis_tready,
  input  logic                                  s_axis_tlast,
  output logic [INPUT_WIDTH*PIXEL_COUNT-1:0]    core_r_all,
  output logic [INPUT_WIDTH*PIXEL_COUNT-1:0]    core_g_all,
  output logic [INPUT_WIDTH*PIXEL_COUNT-1:0]    core_b_all,
  input  logic [NUM_CH*PIXEL_COUNT*DATA_WIDTH-1:0] core_zz_all,
  output logic [DATA_WIDTH-1:0]                 m_axis_tdata,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic                                  m_axis_tlast,
  output logic [1:0]                            m_axis_tuser,
  output logic                                  tlast_err
);

  localparam int PW    = 3*INPUT_WIDTH;
  localparam int CW    = $clog2(PIXEL_COUNT);
  localparam int TOTAL = NUM_CH*PIXEL_COUNT;
  localparam int BW    = $clog2(TOTAL+1);
  localparam int LW    = $clog2(CORE_LATENCY+1);
  localparam int ZW    = TOTAL*DATA_WIDTH;
  localparam int WAIT_END = (CORE_LATENCY >= 2) ? CORE_LATENCY-2 : 0;

  typedef enum logic [1:0] {
    C_IDLE,
    C_WAIT,
    C_HOLD
  } c_state_t;

  logic [PW-1:0] mem [2][PIXEL_COUNT];
  logic [CW-1:0] in_cnt;
  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full;
  logic [1:0]    full_n;
  logic          wr_n;
  logic          acc;
  logic          in_last;
  logic          blk_done;

  c_state_t      c_state;
  c_state_t      c_next;
  logic          load_core;
  logic          cap;
  logic          lat_inc;
  logic [LW-1:0] lat_cnt;

  logic [ZW-1:0] obuf;
  logic          out_full;
  logic [BW-1:0] ld_cnt;
  logic [1:0]    out_ch;
  logic [CW-1:0] out_idx;
  logic          last_out;
  logic          advance;
  logic          fin;

  assign acc      = s_axis_tvalid && s_axis_tready;
  assign in_last  = in_cnt == CW'(PIXEL_COUNT-1);
  assign blk_done = acc && in_last;

  // Release and completion can hit different banks in the same cycle.
  always_comb begin
    full_n = full;
    if (blk_done) full_n[wr_bank] = 1'b1;
    if (cap) full_n[rd_bank] = 1'b0;
    wr_n = wr_bank ^ blk_done;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_cnt        <= '0;
      wr_bank       <= 1'b0;
      full          <= '0;
      s_axis_tready <= 1'b0;
      tlast_err     <= 1'b0;
    end else begin
      full          <= full_n;
      wr_bank       <= wr_n;
      s_axis_tready <= !full_n[wr_n];
      tlast_err     <= acc && (s_axis_tlast != in_last);
      if (acc) in_cnt <= in_last ? '0 : in_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) mem[wr_bank][in_cnt] <= s_axis_tdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) c_state <= C_IDLE;
    else          c_state <= c_next;
  end

  always_comb begin
    c_next    = c_state;
    load_core = 1'b0;
    cap       = 1'b0;
    lat_inc   = 1'b0;
    unique case (c_state)
      C_IDLE: begin
        if (full[rd_bank]) begin
          load_core = 1'b1;
          c_next = (CORE_LATENCY == 1) ? C_HOLD : C_WAIT;
        end
      end
      C_WAIT: begin
        lat_inc = 1'b1;
        if (lat_cnt >= LW'(WAIT_END)) c_next = C_HOLD;
      end
      C_HOLD: begin
        if (!out_full) begin
          cap    = 1'b1;
          c_next = C_IDLE;
        end
      end
      default: c_next = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_cnt    <= '0;
      rd_bank    <= 1'b0;
      core_r_all <= '0;
      core_g_all <= '0;
      core_b_all <= '0;
    end else begin
      if (load_core) begin
        lat_cnt <= '0;
        for (int p = 0; p < PIXEL_COUNT; p++) begin
          core_r_all[p*INPUT_WIDTH +: INPUT_WIDTH] <=
            mem[rd_bank][p][INPUT_WIDTH-1:0];
          core_g_all[p*INPUT_WIDTH +: INPUT_WIDTH] <=
            mem[rd_bank][p][2*INPUT_WIDTH-1:INPUT_WIDTH];
          core_b_all[p*INPUT_WIDTH +: INPUT_WIDTH] <=
            mem[rd_bank][p][3*INPUT_WIDTH-1:2*INPUT_WIDTH];
        end
      end else if (lat_inc) begin
        lat_cnt <= lat_cnt + 1'b1;
      end
      if (cap) rd_bank <= ~rd_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) obuf <= core_zz_all;
  end

  assign advance = !m_axis_tvalid || m_axis_tready;
  assign fin     = m_axis_tvalid && m_axis_tready && last_out;

  // Beat index ld_cnt maps directly onto the flat channel-major buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_full      <= 1'b0;
      ld_cnt        <= '0;
      out_ch        <= '0;
      out_idx       <= '0;
      last_out      <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (cap) out_full <= 1'b1;
      if (advance) begin
        if (out_full && ld_cnt != BW'(TOTAL)) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= obuf[int'(ld_cnt)*DATA_WIDTH +: DATA_WIDTH];
          m_axis_tuser  <= out_ch;
          m_axis_tlast  <= (TLAST_MODE == 0) ?
                           (out_idx == CW'(PIXEL_COUNT-1)) :
                           (ld_cnt == BW'(TOTAL-1));
          last_out      <= ld_cnt == BW'(TOTAL-1);
          ld_cnt        <= ld_cnt + 1'b1;
          if (out_idx == CW'(PIXEL_COUNT-1)) begin
            out_idx <= '0;
            out_ch  <= out_ch + 1'b1;
          end else begin
            out_idx <= out_idx + 1'b1;
          end
        end else begin
          m_axis_tvalid <= 1'b0;
        end
      end
      if (fin) begin
        out_full <= 1'b0;
        ld_cnt   <= '0;
        out_ch   <= '0;
        out_idx  <= '0;
        last_out <= 1'b0;
      end
    end
  end

endmodule
